// File: rtl/dice_dff_measure_sequencer.sv
// Drives the DICE DFF ring measure block through 2^LOG2_SAMPLES start/settle/sample
// rounds and reports average, min, max and zero-count samples for the PVT readout.
module dice_dff_measure_sequencer #(
  parameter int CNT_WIDTH    = 8,
  parameter int LOG2_SAMPLES = 2,
  parameter int WAIT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [CNT_WIDTH-1:0]  meas_cnt,
  output logic                  meas_start,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CNT_WIDTH-1:0]  avg_cnt,
  output logic [CNT_WIDTH-1:0]  min_cnt,
  output logic [CNT_WIDTH-1:0]  max_cnt,
  output logic [LOG2_SAMPLES:0] fail_cnt
);

  localparam int S      = 1 << LOG2_SAMPLES;
  localparam int ACC_W  = CNT_WIDTH + LOG2_SAMPLES;
  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int IDX_W  = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam int FAIL_W = LOG2_SAMPLES + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]    sample_idx_q, sample_idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0] run_min_q, run_min_d;
  logic [CNT_WIDTH-1:0] run_max_q, run_max_d;
  logic [FAIL_W-1:0]   run_fail_q, run_fail_d;
  logic [CNT_WIDTH-1:0] avg_q, avg_d;
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;

  logic [ACC_W-1:0]     acc_next;
  logic [CNT_WIDTH-1:0] min_next;
  logic [CNT_WIDTH-1:0] max_next;
  logic [FAIL_W-1:0]    fail_next;

  // Running statistics with the current sample folded in; only committed in SAMPLE.
  always_comb begin
    acc_next  = acc_q + ACC_W'(meas_cnt);
    min_next  = (meas_cnt < run_min_q) ? meas_cnt : run_min_q;
    max_next  = (meas_cnt > run_max_q) ? meas_cnt : run_max_q;
    fail_next = (meas_cnt == '0) ? run_fail_q + FAIL_W'(1) : run_fail_q;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    sample_idx_d = sample_idx_q;
    acc_d        = acc_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    run_fail_d   = run_fail_q;
    avg_d        = avg_q;
    min_d        = min_q;
    max_d        = max_q;
    fail_d       = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d      = ST_START;
          acc_d        = '0;
          run_min_d    = '1;
          run_max_d    = '0;
          run_fail_d   = '0;
          sample_idx_d = '0;
        end
      end
      ST_START: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_SAMPLE: begin
        acc_d      = acc_next;
        run_min_d  = min_next;
        run_max_d  = max_next;
        run_fail_d = fail_next;
        if (sample_idx_q == IDX_W'(S - 1)) begin
          state_d = ST_DONE;
          avg_d   = CNT_WIDTH'(acc_next >> LOG2_SAMPLES);
          min_d   = min_next;
          max_d   = max_next;
          fail_d  = fail_next;
        end else begin
          state_d      = ST_START;
          sample_idx_d = sample_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      sample_idx_q <= '0;
      acc_q        <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      run_fail_q   <= '0;
      avg_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      fail_q       <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sample_idx_q <= sample_idx_d;
      acc_q        <= acc_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      run_fail_q   <= run_fail_d;
      avg_q        <= avg_d;
      min_q        <= min_d;
      max_q        <= max_d;
      fail_q       <= fail_d;
    end
  end

  assign meas_start   = (state_q == ST_START);
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign avg_cnt      = avg_q;
  assign min_cnt      = min_q;
  assign max_cnt      = max_q;
  assign fail_cnt     = fail_q;

endmodule

// File: tb/tb_dice_dff_measure_sequencer.sv
// Randomized bench for dice_dff_measure_sequencer: per-cycle timing of the Moore
// outputs plus run statistics checked against a sample-list reference model.
module tb_dice_dff_measure_sequencer;

  localparam int CW = 8;
  localparam int L2 = 2;
  localparam int S  = 1 << L2;
  localparam int W  = 64;
  localparam int P  = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger;
  logic [CW-1:0] meas_cnt;
  logic          meas_start;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] avg_cnt;
  logic [CW-1:0] min_cnt;
  logic [CW-1:0] max_cnt;
  logic [L2:0]   fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dice_dff_measure_sequencer #(
    .CNT_WIDTH   (CW),
    .LOG2_SAMPLES(L2),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .meas_cnt    (meas_cnt),
    .meas_start  (meas_start),
    .busy        (busy),
    .result_valid(result_valid),
    .avg_cnt     (avg_cnt),
    .min_cnt     (min_cnt),
    .max_cnt     (max_cnt),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  // Entered at a negedge with the DUT idle. Trigger is high in relative cycle 0;
  // cycle c is observed at the c-th following negedge.
  task automatic run_check(input int smp[S], input bit noise, input string name);
    int sum, mn, mx, nz, k;
    logic exp_ms, exp_busy, exp_rv;
    sum = 0; mn = 255; mx = 0; nz = 0;
    foreach (smp[i]) begin
      sum += smp[i];
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] > mx) mx = smp[i];
      if (smp[i] == 0) nz++;
    end
    trigger  = 1'b1;
    meas_cnt = CW'($urandom);
    @(negedge clk);
    for (int c = 1; c <= S * P + 1; c++) begin
      exp_ms   = ((c - 1) % P == 0) && (c <= S * P);
      exp_busy = 1'b1;
      exp_rv   = (c == S * P + 1);
      n_cmp++;
      if (meas_start !== exp_ms) begin
        n_bad++;
        $display("FAIL %s meas_start cycle %0d: got %b want %b", name, c, meas_start, exp_ms);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, exp_busy);
      end
      n_cmp++;
      if (result_valid !== exp_rv) begin
        n_bad++;
        $display("FAIL %s result_valid cycle %0d: got %b want %b", name, c, result_valid, exp_rv);
      end
      if (exp_rv) begin
        n_cmp++;
        if (avg_cnt !== CW'(sum >> L2)) begin
          n_bad++;
          $display("FAIL %s avg_cnt: got %0d want %0d", name, avg_cnt, sum >> L2);
        end
        n_cmp++;
        if (min_cnt !== CW'(mn)) begin
          n_bad++;
          $display("FAIL %s min_cnt: got %0d want %0d", name, min_cnt, mn);
        end
        n_cmp++;
        if (max_cnt !== CW'(mx)) begin
          n_bad++;
          $display("FAIL %s max_cnt: got %0d want %0d", name, max_cnt, mx);
        end
        n_cmp++;
        if (fail_cnt !== (L2 + 1)'(nz)) begin
          n_bad++;
          $display("FAIL %s fail_cnt: got %0d want %0d", name, fail_cnt, nz);
        end
      end
      // The true sample is presented only in its capture cycle; garbage elsewhere.
      k = (c - 1) / P;
      if (k < S && ((c - 1) % P) == W + 1) meas_cnt = CW'(smp[k]);
      else meas_cnt = CW'($urandom);
      trigger = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    trigger = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || meas_start !== 1'b0) begin
      n_bad++;
      $display("FAIL %s post-run idle: busy=%b rv=%b ms=%b want 0 0 0", name, busy, result_valid, meas_start);
    end
    n_cmp++;
    if (avg_cnt !== CW'(sum >> L2) || min_cnt !== CW'(mn) || max_cnt !== CW'(mx)) begin
      n_bad++;
      $display("FAIL %s result hold: got %0d/%0d/%0d want %0d/%0d/%0d", name, avg_cnt, min_cnt, max_cnt, sum >> L2, mn, mx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b1; meas_cnt = 8'd99;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({meas_start, busy, result_valid, avg_cnt, min_cnt, max_cnt, fail_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: ms=%b busy=%b rv=%b avg=%0d min=%0d max=%0d fail=%0d want all 0",
               meas_start, busy, result_valid, avg_cnt, min_cnt, max_cnt, fail_cnt);
    end
    rst = 1'b0; trigger = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset idle busy: got %b want 0", busy);
    end
  endtask

  task automatic test_patterns();
    int a[S];
    a = '{37, 37, 37, 37};   run_check(a, 1'b0, "const37");
    a = '{10, 20, 30, 45};   run_check(a, 1'b0, "mixed");
    a = '{0, 8, 8, 8};       run_check(a, 1'b0, "one_zero");
    a = '{255, 255, 255, 255}; run_check(a, 1'b0, "all_max");
    a = '{0, 0, 0, 0};       run_check(a, 1'b0, "all_zero");
  endtask

  task automatic test_random();
    int a[S];
    for (int r = 0; r < 6; r++) begin
      foreach (a[i]) a[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      run_check(a, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    int a[S];
    foreach (a[i]) a[i] = int'($urandom_range(1, 255));
    run_check(a, 1'b1, "noisy_trigger");
    foreach (a[i]) a[i] = int'($urandom_range(0, 255));
    run_check(a, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_run();
    int a[S];
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int c = 1; c < 2 * P + 10; c++) begin
      meas_cnt = CW'($urandom_range(1, 255));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({meas_start, busy, result_valid, avg_cnt, min_cnt, max_cnt, fail_cnt} !== '0) begin
      n_bad++;
      $display("FAIL midrun reset outputs: ms=%b busy=%b rv=%b avg=%0d min=%0d max=%0d fail=%0d want all 0",
               meas_start, busy, result_valid, avg_cnt, min_cnt, max_cnt, fail_cnt);
    end
    rst = 1'b0;
    for (int c = 0; c < 3 * P; c++) begin
      meas_cnt = CW'($urandom);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL after-abort cycle %0d: busy=%b rv=%b want 0 0", c, busy, result_valid);
      end
    end
    a = '{5, 3, 9, 1};
    run_check(a, 1'b0, "after_abort");
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; meas_cnt = '0;
    @(negedge clk);
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
